// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences a wide add/subtract through an external 4-bit adder stage
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [W-1:0] op_a_i,
   input  logic [W-1:0] op_b_i,
   input  logic         sub_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] result_o,
   output logic         carry_out_o,
   output logic         overflow_o,
   output logic [3:0]   add_a_o,
   output logic [3:0]   add_b_o,
   output logic         add_cin_o,
   input  logic [3:0]   add_sum_i,
   input  logic         add_cout_i
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            carry_q;
   logic [IW-1:0]   idx_q;
   logic [W-1:0]    result_q;
   logic            cout_q;
   logic            ovf_q;
   logic            busy_q;
   logic            done_q;

   // B is inverted and carry preset to 1 for subtract, so the adder always adds.
   logic [W-1:0]    b_d;
   assign b_d = sub_i ? ~op_b_i : op_b_i;

   // Control FSM: accept in IDLE/DONE, one nibble per RUN cycle, one-cycle DONE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  a_q      <= op_a_i;
                  b_q      <= b_d;
                  carry_q  <= sub_i;
                  idx_q    <= '0;
                  result_q <= '0;
                  cout_q   <= 1'b0;
                  ovf_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end else begin
                  state_q  <= S_IDLE;
               end
            end
            S_RUN: begin
               result_q[4*idx_q +: 4] <= add_sum_i;
               carry_q                <= add_cout_i;
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= add_cout_i;
                  ovf_q   <= (a_q[W-1] == b_q[W-1]) && (add_sum_i[3] != a_q[W-1]);
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Adder operands are only driven while a nibble is in flight.
   always_comb begin
      add_a_o   = 4'h0;
      add_b_o   = 4'h0;
      add_cin_o = 1'b0;
      if (state_q == S_RUN) begin
         add_a_o   = a_q[4*idx_q +: 4];
         add_b_o   = b_q[4*idx_q +: 4];
         add_cin_o = carry_q;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign result_o    = result_q;
   assign carry_out_o = cout_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        sub;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry_out;
   logic        overflow;
   logic [3:0]  add_a;
   logic [3:0]  add_b;
   logic        add_cin;
   logic [3:0]  add_sum;
   logic        add_cout;

   int checks = 0;
   int errors = 0;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .op_a_i      (op_a),
      .op_b_i      (op_b),
      .sub_i       (sub),
      .busy_o      (busy),
      .done_o      (done),
      .result_o    (result),
      .carry_out_o (carry_out),
      .overflow_o  (overflow),
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_cin_o   (add_cin),
      .add_sum_i   (add_sum),
      .add_cout_i  (add_cout)
   );

   // External 4-bit adder stage
   logic [4:0] adder_full;
   assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
   assign add_sum    = adder_full[3:0];
   assign add_cout   = adder_full[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, carry_out, result} from plain integer arithmetic
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
      int          sa, sb, t;
      logic [15:0] r;
      logic        c, v;
      logic [16:0] wide;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (s) begin
         r = a - b;
         c = (a >= b);
         t = sa - sb;
      end else begin
         wide = {1'b0, a} + {1'b0, b};
         r = wide[15:0];
         c = wide[16];
         t = sa + sb;
      end
      v = (t > 32767) || (t < -32768);
      return {v, c, r};
   endfunction

   // Drive a start request at the current negedge; returns one negedge later with start low.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      sub   = s;
      @(negedge clk);
      start = 1'b0;
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      sub   = 1'($urandom);
   endtask

   // Called at the negedge of RUN cycle 0; walks RUN and checks the DONE cycle outputs.
   task automatic finish_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input bit inject, output logic [3:0] cins);
      logic [17:0] exp;
      logic [15:0] bb;
      exp = model(a, b, s);
      bb  = s ? ~b : b;
      for (int i = 0; i < 4; i++) begin
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " done_low"}, 32'(done), 32'd0);
         check({tag, " add_a"}, 32'(add_a), 32'((a >> (4 * i)) & 16'h000F));
         check({tag, " add_b"}, 32'(add_b), 32'((bb >> (4 * i)) & 16'h000F));
         cins[i] = add_cin;
         if (inject && i == 1) begin
            start = 1'b1;
            op_a  = 16'($urandom);
            op_b  = 16'($urandom);
            sub   = ~s;
         end
         @(negedge clk);
         if (inject && i == 1) start = 1'b0;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy_low"}, 32'(busy), 32'd0);
      check({tag, " result"}, 32'(result), 32'(exp[15:0]));
      check({tag, " carry_out"}, 32'(carry_out), 32'(exp[16]));
      check({tag, " overflow"}, 32'(overflow), 32'(exp[17]));
      check({tag, " add_idle"}, 32'({add_a, add_b, add_cin}), 32'd0);
   endtask

   task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, output logic [3:0] cins);
      issue(a, b, s);
      finish_op(tag, a, b, s, 1'b0, cins);
      @(negedge clk);
      check({tag, " done_pulse_end"}, 32'(done), 32'd0);
      check({tag, " result_hold"}, 32'(result), 32'(model(a, b, s) & 18'h0FFFF));
   endtask

   initial begin
      logic [3:0]  cins;
      logic [15:0] ra, rb;
      logic        rs;
      rst_n = 1'b0;
      start = 1'b0;
      op_a  = 16'h0;
      op_b  = 16'h0;
      sub   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_flags", 32'({carry_out, overflow}), 32'd0);
      check("reset_adder", 32'({add_a, add_b, add_cin}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      full_op("plain_add", 16'h1234, 16'h4321, 1'b0, cins);
      full_op("ripple", 16'hFFFF, 16'h0001, 1'b0, cins);
      check("ripple_cin_seq", 32'(cins), 32'(4'b1110));
      full_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, cins);
      full_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, cins);
      full_op("sub_small", 16'h0005, 16'h0007, 1'b1, cins);
      check("sub_cin_first", 32'(cins[0]), 32'd1);
      full_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, cins);

      // start during RUN is ignored
      issue(16'h1111, 16'h2222, 1'b0);
      finish_op("ignore_start", 16'h1111, 16'h2222, 1'b0, 1'b1, cins);
      @(negedge clk);
      check("ignore_start_idle", 32'({busy, done}), 32'd0);

      // reset during the second RUN cycle aborts
      issue(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_flags", 32'({carry_out, overflow}), 32'd0);
      check("abort_adder", 32'({add_a, add_b, add_cin}), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_still_idle", 32'({busy, done}), 32'd0);
      full_op("after_abort", 16'h0001, 16'h0001, 1'b0, cins);
      check("after_abort_value", 32'(result), 32'h0002);

      // back-to-back: second start issued in the DONE cycle
      issue(16'h0F0F, 16'h0101, 1'b0);
      finish_op("b2b_first", 16'h0F0F, 16'h0101, 1'b0, 1'b0, cins);
      issue(16'h00FF, 16'h0001, 1'b0);
      check("b2b_busy_rise", 32'(busy), 32'd1);
      check("b2b_no_overlap", 32'(done), 32'd0);
      finish_op("b2b_second", 16'h00FF, 16'h0001, 1'b0, 1'b0, cins);
      check("b2b_value", 32'(result), 32'h0100);
      @(negedge clk);

      // randomized operations against the model
      for (int n = 0; n < 24; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         if (n % 6 == 0) rb = ra;
         full_op($sformatf("rand%0d", n), ra, rb, rs, cins);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
